// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: port-engine and controller-side bus bundle for the SDRAM port arbiter
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0][31:0] p_adr_i;
    logic [NUM_PORTS-1:0][15:0] p_dat_i;
    logic [NUM_PORTS-1:0][1:0]  p_sel_i;
    logic [NUM_PORTS-1:0]       p_acc_i;
    logic [NUM_PORTS-1:0]       p_we_i;
    logic [NUM_PORTS-1:0]       p_ack_o;
    logic [15:0]                p_dat_o;
    logic [31:0]                adr_o;
    logic [15:0]                dat_o;
    logic [1:0]                 sel_o;
    logic                       acc_o;
    logic                       we_o;
    logic                       ack_i;
    logic [15:0]                dat_i;

    modport slave (
        input  p_adr_i, p_dat_i, p_sel_i, p_acc_i, p_we_i, ack_i, dat_i,
        output p_ack_o, p_dat_o, adr_o, dat_o, sel_o, acc_o, we_o
    );

    modport master (
        output p_adr_i, p_dat_i, p_sel_i, p_acc_i, p_we_i, ack_i, dat_i,
        input  p_ack_o, p_dat_o, adr_o, dat_o, sel_o, acc_o, we_o
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin owner selection for the SDRAM controller, grant held across short acc gaps
module sdram_port_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int RELEASE_DLY = 4
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst_n,
    sdram_port_arbiter_if.slave   bus,
    output logic [NUM_PORTS-1:0]  grant_o,
    output logic                  proto_err_o
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(RELEASE_DLY + 1);

    typedef enum logic [1:0] {IDLE, OWNED, HOLD} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d, last_q, last_d, pick, k;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 err_q, err_d;
    logic                 owned;

    // round-robin pick: scan downward so the nearest requester after last_q wins
    always_comb begin
        pick = last_q;
        k    = last_q;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            k = IW'((int'(last_q) + i) % NUM_PORTS);
            if (bus.p_acc_i[k]) pick = k;
        end
    end

    // next-state: ownership only changes in IDLE; HOLD counts the owner's acc gap
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        err_d   = (state_q == IDLE) && bus.ack_i;
        case (state_q)
            IDLE: if (|bus.p_acc_i) begin
                state_d = OWNED;
                owner_d = pick;
                grant_d = NUM_PORTS'(1) << pick;
            end
            OWNED: if (!bus.p_acc_i[owner_q]) begin
                state_d = HOLD;
                cnt_d   = CW'(1);
            end
            HOLD: if (bus.p_acc_i[owner_q]) begin
                state_d = OWNED;
                cnt_d   = '0;
            end else if (cnt_q == CW'(RELEASE_DLY)) begin
                state_d = IDLE;
                last_d  = owner_q;
                grant_d = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register with synchronous active-low reset; port 0 wins first after reset
    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    // owner's signals pass straight through; everything is zero with no owner
    always_comb begin
        owned       = state_q != IDLE;
        bus.adr_o   = owned ? bus.p_adr_i[owner_q] : '0;
        bus.dat_o   = owned ? bus.p_dat_i[owner_q] : '0;
        bus.sel_o   = owned ? bus.p_sel_i[owner_q] : '0;
        bus.we_o    = owned && bus.p_we_i[owner_q];
        bus.acc_o   = owned && bus.p_acc_i[owner_q];
        bus.p_ack_o = (owned && bus.ack_i) ? grant_q : '0;
        bus.p_dat_o = bus.dat_i;
        grant_o     = grant_q;
        proto_err_o = err_q;
    end
endmodule
